ps2_rx_fifo: RTL

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes and deglitches the PS/2 lines, deserializes
// 11-bit frames, folds E0/F0 prefixes into 16-bit codes and queues them in a show-ahead FIFO.
module ps2_rx_fifo #(
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned FIFO_DEPTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ps2clk,
   input  logic                         ps2data,
   output logic [15:0]                  code,
   output logic                         code_ext,
   output logic                         code_valid,
   input  logic                         code_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                         overflow,
   output logic                         parity_err,
   output logic                         frame_err
);

   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned FW   = $clog2(FILTER_LEN + 1);
   localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned EW   = 10;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DATA   = 2'd1;
   localparam logic [1:0] S_PARITY = 2'd2;
   localparam logic [1:0] S_STOP   = 2'd3;

   // Two-flop synchronizers, both idle high
   logic [1:0] clk_sync;
   logic [1:0] data_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2clk};
         data_sync <= {data_sync[0], ps2data};
      end
   end

   // Filtered level flips only after FILTER_LEN consecutive differing samples
   logic          filt;
   logic          filt_d;
   logic [FW-1:0] filt_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt     <= 1'b1;
         filt_d   <= 1'b1;
         filt_cnt <= '0;
      end else begin
         filt_d <= filt;
         if (clk_sync[1] == filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt     <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + FW'(1);
         end
      end
   end

   logic sample_c;
   logic data_bit;
   assign sample_c = filt_d & ~filt;
   assign data_bit = data_sync[1];

   // Receive FSM
   logic [1:0]    state, state_n;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n;
   logic [TW-1:0] timer, timer_n;
   logic          done_n, perr_n, ferr_n, clr_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         timer      <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         par        <= par_n;
         timer      <= timer_n;
         parity_err <= perr_n;
         frame_err  <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_n     = par;
      timer_n   = (state == S_IDLE || sample_c) ? '0 : timer + TW'(1);
      done_n    = 1'b0;
      perr_n    = 1'b0;
      ferr_n    = 1'b0;
      clr_n     = 1'b0;
      case (state)
         S_IDLE: begin
            if (sample_c && !data_bit) begin
               state_n   = S_DATA;
               bit_cnt_n = '0;
               par_n     = 1'b0;
            end
         end
         S_DATA: begin
            if (sample_c) begin
               shreg_n   = {data_bit, shreg[7:1]};
               par_n     = par ^ data_bit;
               bit_cnt_n = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_n = S_PARITY;
            end
         end
         S_PARITY: begin
            if (sample_c) begin
               par_n   = par ^ data_bit;
               state_n = S_STOP;
            end
         end
         default: begin
            if (sample_c) begin
               state_n = S_IDLE;
               if (!data_bit) begin
                  ferr_n = 1'b1;
                  clr_n  = 1'b1;
               end else if (!par) begin
                  perr_n = 1'b1;
                  clr_n  = 1'b1;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
      endcase
      // Stalled frame: abandon it and report a framing error
      if (state != S_IDLE && !sample_c && timer == TW'(TIMEOUT_CYCLES - 1)) begin
         state_n = S_IDLE;
         timer_n = '0;
         ferr_n  = 1'b1;
         clr_n   = 1'b1;
      end
   end

   // Completed byte is decoded against the prefix flags one cycle after the stop sample
   logic       byte_rdy;
   logic [7:0] byte_q;
   logic       ext, brk;
   logic       push;
   logic       is_prefix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_rdy <= 1'b0;
         byte_q   <= '0;
      end else begin
         byte_rdy <= done_n;
         if (done_n) byte_q <= shreg;
      end
   end

   assign is_prefix = (byte_q == 8'hE0) || (byte_q == 8'hF0);
   assign push      = byte_rdy && !is_prefix;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (clr_n) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_rdy) begin
         if (byte_q == 8'hE0) begin
            ext <= 1'b1;
         end else if (byte_q == 8'hF0) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
         end
      end
   end

   // Show-ahead FIFO of {brk, ext, byte}
   logic [EW-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            empty, full, pop, push_ok;
   logic [EW-1:0]   head;

   assign empty   = (count == '0);
   assign full    = (count == CNTW'(FIFO_DEPTH));
   assign pop     = !empty && code_ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= {brk, ext, byte_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + CNTW'(1);
         else if (!push_ok && pop) count <= count - CNTW'(1);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   assign head       = mem[rd_ptr];
   assign code_valid = !empty;
   assign code_ext   = !empty && head[8];
   assign code       = empty ? 16'h0000 :
                       {(head[9] ? 8'hF0 : (head[8] ? 8'hE0 : 8'h00)), head[7:0]};
   assign fifo_count = count;

endmodule
